// File: rtl/in_to_stage.sv
// Block-input to FFT stage-buffer filler: writes one N-sample frame plus per-sample metadata.
// Optional `IN_TO_STAGE_BITREV_EN selects bit-reversed write addresses (DIT input order).
module in_to_stage #(
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_nd,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MWIDTH-1:0] in_m,
  input  logic              in_mfull,
  output logic [LOG_N-1:0]  out_addr,
  output logic              out_nd,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_mwrite,
  output logic [MWIDTH-1:0] out_m,
  output logic              finished,
  output logic              active,
  output logic              error
);

  logic              active_q, active_d;
  logic [LOG_N-1:0]  count_q, count_d;
  logic              last_q, last_d;
  logic              error_q, error_d;
  logic [LOG_N-1:0]  addr_q, addr_d;
  logic              nd_q, nd_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              mwrite_q, mwrite_d;
  logic [MWIDTH-1:0] m_q, m_d;
  logic              fin_q, fin_d;

  logic              accept;
  logic [LOG_N-1:0]  idx;

  function automatic logic [LOG_N-1:0] addr_map(input logic [LOG_N-1:0] k);
    logic [LOG_N-1:0] r;
`ifdef IN_TO_STAGE_BITREV_EN
    for (int b = 0; b < LOG_N; b++) r[b] = k[LOG_N-1-b];
`else
    r = k;
`endif
    return r;
  endfunction

  // A start from idle with a coincident sample takes that sample as index 0.
  assign idx    = active_q ? count_q : '0;
  assign accept = in_nd & (active_q | start);

  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    last_d   = 1'b0;
    error_d  = error_q;
    addr_d   = addr_q;
    nd_d     = 1'b0;
    data_d   = data_q;
    mwrite_d = 1'b0;
    m_d      = m_q;
    fin_d    = last_q;

    if (start & active_q) error_d = 1'b1;
    if (in_nd & ~active_q & ~start) error_d = 1'b1;
    if (start & ~active_q) begin
      active_d = 1'b1;
      count_d  = '0;
    end

    if (accept) begin
      nd_d     = 1'b1;
      mwrite_d = 1'b1;
      data_d   = in_data;
      m_d      = in_m;
      addr_d   = addr_map(idx);
      count_d  = idx + LOG_N'(1);
      if (in_mfull) error_d = 1'b1;
      if (idx == LOG_N'(N-1)) begin
        active_d = 1'b0;
        last_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      count_q  <= '0;
      last_q   <= 1'b0;
      error_q  <= 1'b0;
      addr_q   <= '0;
      nd_q     <= 1'b0;
      data_q   <= '0;
      mwrite_q <= 1'b0;
      m_q      <= '0;
      fin_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      last_q   <= last_d;
      error_q  <= error_d;
      addr_q   <= addr_d;
      nd_q     <= nd_d;
      data_q   <= data_d;
      mwrite_q <= mwrite_d;
      m_q      <= m_d;
      fin_q    <= fin_d;
    end
  end

  assign out_addr   = addr_q;
  assign out_nd     = nd_q;
  assign out_data   = data_q;
  assign out_mwrite = mwrite_q;
  assign out_m      = m_q;
  assign finished   = fin_q;
  assign active     = active_q | start;
  assign error      = error_q;

endmodule
